// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the board front end / ALU and the operand sequencer.
// The master side drives the user inputs and the ALU response; the slave side is the sequencer.
interface alu_seq_ctrl_if #(
  parameter int unsigned bits     = 8,
  parameter int unsigned cnt_bits = 8
);
  logic [bits-1:0]     data_in;
  logic [1:0]          op_in;
  logic                enter;
  logic                back;
  logic                chain;
  logic [bits-1:0]     alu_a;
  logic [bits-1:0]     alu_b;
  logic [1:0]          alu_op;
  logic [bits:0]       alu_res;
  logic                alu_invalido;
  logic [bits:0]       result;
  logic                result_valid;
  logic                invalido;
  logic [2:0]          state_out;
  logic [cnt_bits-1:0] op_count;

  modport master (
    output data_in, op_in, enter, back, chain, alu_res, alu_invalido,
    input  alu_a, alu_b, alu_op, result, result_valid, invalido, state_out, op_count
  );

  modport slave (
    input  data_in, op_in, enter, back, chain, alu_res, alu_invalido,
    output alu_a, alu_b, alu_op, result, result_valid, invalido, state_out, op_count
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Operand-capture sequencer for the shared combinational ALU: captures A, B, opcode,
// runs one execute cycle, latches result/invalid flag for display, supports back and chain.
module alu_seq_ctrl #(
  parameter int unsigned bits     = 8,
  parameter int unsigned cnt_bits = 8
) (
  input logic          clk,
  input logic          reset_n,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [bits-1:0]     a_q, a_d;
  logic [bits-1:0]     b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [bits:0]       res_q, res_d;
  logic                inv_q, inv_d;
  logic                valid_q, valid_d;
  logic [cnt_bits-1:0] cnt_q, cnt_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and capture logic; pulse priority is enter > chain > back
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    inv_d   = inv_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    case (state_q)
      WAIT_A: begin
        if (bus.enter) begin
          a_d     = bus.data_in;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.enter) begin
          b_d     = bus.data_in;
          state_d = WAIT_OP;
        end else if (bus.back) begin
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (bus.enter) begin
          op_d    = bus.op_in;
          state_d = EXEC;
        end else if (bus.back) begin
          state_d = WAIT_B;
        end
      end
      EXEC: begin
        res_d   = bus.alu_res;
        inv_d   = bus.alu_invalido;
        valid_d = 1'b1;
        cnt_d   = (cnt_q == {cnt_bits{1'b1}}) ? cnt_q : cnt_q + cnt_bits'(1);
        state_d = SHOW;
      end
      SHOW: begin
        if (bus.enter) begin
          valid_d = 1'b0;
          state_d = WAIT_A;
        end else if (bus.chain) begin
          // An invalid result still consumes the chain pulse, masking a concurrent back
          if (!inv_q) begin
            a_d     = res_q[bits-1:0];
            valid_d = 1'b0;
            state_d = WAIT_B;
          end
        end else if (bus.back) begin
          valid_d = 1'b0;
          state_d = WAIT_OP;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_op       = op_q;
  assign bus.result       = res_q;
  assign bus.invalido     = inv_q;
  assign bus.result_valid = valid_q;
  assign bus.state_out    = state_q;
  assign bus.op_count     = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU; a second instance with a
// 2-bit counter runs in lockstep to exercise op_count saturation.
module tb_alu_seq_ctrl;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  alu_seq_ctrl_if #(.bits(8), .cnt_bits(8)) ifm ();
  alu_seq_ctrl_if #(.bits(8), .cnt_bits(2)) ifs ();

  alu_seq_ctrl #(.bits(8), .cnt_bits(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifm.slave)
  );

  alu_seq_ctrl #(.bits(8), .cnt_bits(2)) dut_sat (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: carry/borrow lands in bit 8 and flags invalid for add/sub
  function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
    logic [8:0] r;
    logic       inv;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} - {1'b0, b};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    inv = (op[1] == 1'b0) ? r[8] : 1'b0;
    return {inv, r};
  endfunction

  assign {ifm.alu_invalido, ifm.alu_res} = alu_model(ifm.alu_a, ifm.alu_b, ifm.alu_op);
  assign {ifs.alu_invalido, ifs.alu_res} = alu_model(ifs.alu_a, ifs.alu_b, ifs.alu_op);
  assign ifs.data_in = ifm.data_in;
  assign ifs.op_in   = ifm.op_in;
  assign ifs.enter   = ifm.enter;
  assign ifs.back    = ifm.back;
  assign ifs.chain   = ifm.chain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ifm.enter = 1'b0;
    ifm.back  = 1'b0;
    ifm.chain = 1'b0;
  endtask

  task automatic pulse(input logic e, input logic c, input logic b);
    ifm.enter = e;
    ifm.chain = c;
    ifm.back  = b;
    tick();
  endtask

  task automatic enter_val(input logic [7:0] v);
    ifm.data_in = v;
    pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic enter_op(input logic [1:0] o);
    ifm.op_in = o;
    pulse(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n     = 1'b0;
    ifm.data_in = '0;
    ifm.op_in   = '0;
    ifm.enter   = 1'b0;
    ifm.back    = 1'b0;
    ifm.chain   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_state", 32'(ifm.state_out), 32'd0);
    chk("rst_alu_a", 32'(ifm.alu_a), 32'd0);
    chk("rst_result", 32'(ifm.result), 32'd0);
    chk("rst_valid", 32'(ifm.result_valid), 32'd0);
    chk("rst_inv", 32'(ifm.invalido), 32'd0);
    chk("rst_count", 32'(ifm.op_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Add with overflow
    pulse(1'b0, 1'b1, 1'b1);
    chk("waita_ignore", 32'(ifm.state_out), 32'd0);
    enter_val(8'd200);
    enter_val(8'd100);
    enter_op(2'b00);
    chk("exec_state", 32'(ifm.state_out), 32'd3);
    chk("exec_valid", 32'(ifm.result_valid), 32'd0);
    tick();
    chk("add_state", 32'(ifm.state_out), 32'd4);
    chk("add_valid", 32'(ifm.result_valid), 32'd1);
    chk("add_result", 32'(ifm.result), 32'h12C);
    chk("add_inv", 32'(ifm.invalido), 32'd1);
    chk("add_count", 32'(ifm.op_count), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("show_exit_state", 32'(ifm.state_out), 32'd0);
    chk("show_exit_valid", 32'(ifm.result_valid), 32'd0);
    chk("show_exit_hold", 32'(ifm.result), 32'h12C);

    // Sub negative; chain blocked by invalid result
    enter_val(8'd5);
    enter_val(8'd7);
    enter_op(2'b01);
    tick();
    chk("sub_result", 32'(ifm.result), 32'h1FE);
    chk("sub_inv", 32'(ifm.invalido), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("sub_chain_state", 32'(ifm.state_out), 32'd4);
    chk("sub_chain_a", 32'(ifm.alu_a), 32'd5);
    pulse(1'b1, 1'b0, 1'b0);

    // Chain a valid result into A
    enter_val(8'd3);
    enter_val(8'd4);
    enter_op(2'b00);
    tick();
    chk("chain_src_result", 32'(ifm.result), 32'd7);
    chk("chain_src_inv", 32'(ifm.invalido), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("chain_state", 32'(ifm.state_out), 32'd1);
    chk("chain_a", 32'(ifm.alu_a), 32'd7);
    chk("chain_valid", 32'(ifm.result_valid), 32'd0);
    enter_val(8'd10);
    enter_op(2'b10);
    tick();
    chk("chain_and_a", 32'(ifm.alu_a), 32'd7);
    chk("chain_and_result", 32'(ifm.result), 32'h002);
    chk("count4", 32'(ifm.op_count), 32'd4);
    pulse(1'b1, 1'b0, 1'b0);

    // Back navigation keeps operands
    enter_val(8'd9);
    enter_val(8'd6);
    pulse(1'b0, 1'b0, 1'b1);
    chk("back1_state", 32'(ifm.state_out), 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("back2_state", 32'(ifm.state_out), 32'd0);
    chk("back_a_kept", 32'(ifm.alu_a), 32'd9);
    chk("back_b_kept", 32'(ifm.alu_b), 32'd6);
    enter_val(8'd1);
    enter_val(8'd2);
    enter_op(2'b11);
    tick();
    chk("or_result", 32'(ifm.result), 32'd3);
    chk("count5", 32'(ifm.op_count), 32'd5);
    chk("sat_count", 32'(ifs.op_count), 32'd3);
    pulse(1'b0, 1'b0, 1'b1);
    chk("show_back_state", 32'(ifm.state_out), 32'd2);
    chk("show_back_valid", 32'(ifm.result_valid), 32'd0);
    enter_op(2'b11);
    tick();
    chk("rerun_state", 32'(ifm.state_out), 32'd4);
    chk("count6", 32'(ifm.op_count), 32'd6);
    chk("sat_hold", 32'(ifs.op_count), 32'd3);
    pulse(1'b1, 1'b0, 1'b0);

    // Simultaneous pulses
    enter_val(8'd4);
    ifm.data_in = 8'd8;
    pulse(1'b1, 1'b0, 1'b1);
    chk("eb_state", 32'(ifm.state_out), 32'd2);
    chk("eb_b", 32'(ifm.alu_b), 32'd8);
    enter_op(2'b00);
    tick();
    chk("eb_result", 32'(ifm.result), 32'h00C);
    pulse(1'b0, 1'b1, 1'b1);
    chk("cb_state", 32'(ifm.state_out), 32'd1);
    chk("cb_a", 32'(ifm.alu_a), 32'h0C);

    // Reset during EXEC
    enter_val(8'd1);
    enter_op(2'b00);
    chk("pre_rst_exec", 32'(ifm.state_out), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(ifm.state_out), 32'd0);
    chk("mid_rst_result", 32'(ifm.result), 32'd0);
    chk("mid_rst_valid", 32'(ifm.result_valid), 32'd0);
    chk("mid_rst_count", 32'(ifm.op_count), 32'd0);
    chk("mid_rst_a", 32'(ifm.alu_a), 32'd0);
    tick();
    chk("rst_held_state", 32'(ifm.state_out), 32'd0);
    chk("rst_held_result", 32'(ifm.result), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
